// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM state encoding for the parameterised register file.
package regfile_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefDepth = 32;
    localparam int unsigned DefNumRd = 2;

    typedef enum logic {
        StIdle,
        StClear
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep controller: walks registers 1..DEPTH-1, one per cycle, then pulses done.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear_req,
    output logic              o_busy,
    output logic              o_clear_done,
    output logic              o_sweep_we,
    output logic [ADDR_W-1:0] o_sweep_addr
);

    clr_state_e        r_state;
    clr_state_e        w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_done;
    logic              w_last;

    assign w_last = (r_cnt == ADDR_W'(DEPTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_clear_req) w_state_next = StClear;
            StClear: if (w_last)      w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Counter idles at 1 so a new sweep starts on register 1 without extra load logic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= ADDR_W'(1);
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == StClear) && w_last;
            if (r_state == StClear) begin
                r_cnt <= w_last ? ADDR_W'(1) : r_cnt + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        o_busy       = (r_state == StClear);
        o_sweep_we   = (r_state == StClear);
        o_sweep_addr = r_cnt;
        o_clear_done = r_done;
    end

endmodule

// File: rtl/param_register_file.sv
// Multi-read-port register file with hardwired-zero register 0 and a sweeping clear.
// Define PARAM_REGISTER_FILE_BYPASS_EN to forward an accepted write to same-cycle reads.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned NUM_RD = DefNumRd,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        regNo,
    input  logic [DATA_W-1:0]        writeData,
    input  logic [NUM_RD*ADDR_W-1:0] readRegs,
    output logic [NUM_RD*DATA_W-1:0] readData,
    input  logic                     clearReq,
    output logic                     busy,
    output logic                     clearDone
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_busy;
    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_wr_en;

    regfile_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .i_clk        (clk),
        .i_rst        (reset),
        .i_clear_req  (clearReq),
        .o_busy       (w_busy),
        .o_clear_done (clearDone),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    assign busy    = w_busy;
    assign w_wr_en = write && !w_busy && (regNo != '0) && (32'(regNo) < DEPTH);

    // Entry 0 is never addressed by either write source, so it stays at its reset zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sweep_we && (w_sweep_addr == ADDR_W'(i))) begin
                    r_mem[i] <= '0;
                end else if (w_wr_en && (regNo == ADDR_W'(i))) begin
                    r_mem[i] <= writeData;
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_rd_addr;
        w_rd_addr = '0;
        readData  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_addr = readRegs[k*ADDR_W +: ADDR_W];
            if ((w_rd_addr != '0) && (32'(w_rd_addr) < DEPTH)) begin
                readData[k*DATA_W +: DATA_W] = r_mem[w_rd_addr];
            end
`ifdef PARAM_REGISTER_FILE_BYPASS_EN
            if (w_wr_en && (w_rd_addr == regNo)) begin
                readData[k*DATA_W +: DATA_W] = writeData;
            end
`endif
        end
    end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning the number of registers (minimum 2).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning the number of independent read ports (minimum 1).
REQ-004 SHALL have derived localparam ADDR_W = clog2(DEPTH), meaning the address width.
REQ-005 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have write  input  1  write enable, sampled on clk rise.
REQ-008 SHALL have regNo  input  ADDR_W  write address.
REQ-009 SHALL have writeData  input  DATA_W  write data.
REQ-010 SHALL have readRegs  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have readData  output  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have clearReq  input  1  request to zero all registers.
REQ-013 SHALL have busy  output  1  high while a clear sweep is in progress.
REQ-014 SHALL have clearDone  output  1  single-cycle pulse marking the end of a clear sweep.

Function
REQ-015 SHALL write writeData into register regNo on the rising clk edge when write=1, busy=0 and 0<regNo<DEPTH.
REQ-016 SHALL hardwire register 0 to zero: writes to it are ignored and reads of it return 0.
REQ-017 SHALL return readData for every port combinationally from its readRegs slice; ports are fully independent and may share an address.
REQ-018 SHALL ignore writes to addresses >= DEPTH and return 0 for reads of addresses >= DEPTH.
REQ-019 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-020 SHALL move IDLE->CLEAR on a clk edge with clearReq=1, load the sweep counter with 1 and set busy=1 on that edge.
REQ-021 SHALL, in CLEAR, zero the register addressed by the counter on each edge and then increment the counter; sweeping registers 1..DEPTH-1 takes DEPTH-1 cycles.
REQ-022 SHALL return to IDLE on the edge that clears register DEPTH-1, drop busy and assert clearDone for exactly the following cycle.
REQ-023 SHALL drop port writes (write=1) while busy=1, with no queuing and no error indication.
REQ-024 SHALL ignore clearReq while busy=1; a clearReq held high on the clearDone cycle starts a new sweep.
REQ-025 SHALL let reads during CLEAR return current contents: already-swept registers read 0, the rest keep their old values.

Reset
REQ-026 SHALL, on reset high and independent of clk, zero all registers, force the FSM to IDLE, set the counter to 1, and drive busy=0 and clearDone=0.
REQ-027 SHALL abandon a clear sweep when reset is asserted mid-sweep; after reset release, all registers read 0 and busy=0.
REQ-028 SHALL ignore write and clearReq for the whole time reset is high.

Configuration
REQ-029 SHALL, when macro PARAM_REGISTER_FILE_BYPASS_EN is defined, forward writeData to any read port whose address equals regNo in the same cycle that an accepted write (per REQ-015) is presented.
REQ-030 SHALL, when PARAM_REGISTER_FILE_BYPASS_EN is undefined, return the stored value on every read, so written data appears only after the clk edge.

Structure
REQ-031 SHALL take its FSM state encoding (IDLE, CLEAR) and the default parameter constants from shared package regfile_pkg.
REQ-032 SHALL place the clear FSM and sweep counter in sub-module regfile_clear_ctrl, which outputs busy, clearDone, the sweep address and a sweep-write strobe.

Verification
REQ-033 SHALL cover: write regNo=1..31 with data=regNo, then read ports (0,1) and (31,5) -> readData 0/1 and 31/5.
REQ-034 SHALL cover: write=1, regNo=0, writeData=32'hFFFFFFFF, then read 0 -> 0.
REQ-035 SHALL cover: regNo=3, writeData=32'h39CE7F9E, readReg0=3 in the same cycle -> 32'h39CE7F9E before the edge with bypass enabled; old value before the edge and new value after it with bypass disabled.
REQ-036 SHALL cover: fill all registers, pulse clearReq, present write to reg 5 mid-sweep -> busy high for 31 cycles, clearDone one cycle, all registers 0, write dropped.
REQ-037 SHALL cover: reset asserted at sweep cycle 10 with reg 20 = 32'hC0100420 -> all registers 0 immediately, busy=0, clearDone never pulses.
REQ-038 SHALL cover: NUM_RD=4, DEPTH=24, read address 27 on port 3 and write to address 30 -> port 3 reads 0 and no register changes.
